// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - controller command encodings and sequencer state type
//
// Shared by the burst sequencer and anything that watches its command bus.
// CMD_* are the 3-bit opcodes understood by the controller user interface.
// state_t enumerates the sequencer FSM states.

package sdram_pkg;

  localparam logic [2:0] CMD_NOP    = 3'b111;
  localparam logic [2:0] CMD_ACTIVE = 3'b011;
  localparam logic [2:0] CMD_WRITE  = 3'b100;
  localparam logic [2:0] CMD_READ   = 3'b101;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACTIVATE,
    ST_ACT_WAIT,
    ST_WRITE,
    ST_READ_CMD,
    ST_READ_WAIT,
    ST_READ_BEATS,
    ST_RECOVER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sdram_burst_sequencer.sv
// rtl/sdram_burst_sequencer.sv - whole-line read/write command sequencer for the SDRAM controller
//
// Accepts one cache-line request and issues ACTIVE, a NOP gap, then a READ or
// WRITE burst of BURST_BEATS words to the controller user interface.
// RECOVER_CYCLES must be at least 1.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake; req_write, req_address, req_line
//   rsp_line                 last line read, beat k at [k*W +: W]
//   done                     one-cycle completion pulse
//   busy                     high whenever the sequencer is not idle
//   sdrc_*                   outputs to the controller user interface
//   sdrc_rd_data             read data from the controller
//   sdrc_init_done           controller initialisation complete

module sdram_burst_sequencer
  import sdram_pkg::*;
#(
  parameter int ADDRESS_BIT_WIDTH   = 21,
  parameter int DATA_BIT_WIDTH      = 32,
  parameter int BURST_BEATS         = 8,
  parameter int ACT_TO_RW_CYCLES    = 1,
  parameter int READ_LATENCY_CYCLES = 5,
  parameter int RECOVER_CYCLES      = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [ADDRESS_BIT_WIDTH-1:0]          req_address,
  input  logic [BURST_BEATS*DATA_BIT_WIDTH-1:0] req_line,
  output logic [BURST_BEATS*DATA_BIT_WIDTH-1:0] rsp_line,
  output logic                                  done,
  output logic                                  busy,
  output logic                                  sdrc_cmd_en,
  output logic [2:0]                            sdrc_cmd,
  output logic [ADDRESS_BIT_WIDTH-1:0]          sdrc_addr,
  output logic [3:0]                            sdrc_dqm,
  output logic [DATA_BIT_WIDTH-1:0]             sdrc_data,
  output logic [7:0]                            sdrc_data_len,
  output logic                                  sdrc_precharge_ctrl,
  output logic                                  sdrc_power_down,
  output logic                                  sdrc_selfrefresh,
  input  logic [DATA_BIT_WIDTH-1:0]             sdrc_rd_data,
  input  logic                                  sdrc_init_done
);

  localparam int LINE_W  = BURST_BEATS * DATA_BIT_WIDTH;
  localparam int BEAT_W  = $clog2(BURST_BEATS) + 1;
  localparam int DLY_AR  = (ACT_TO_RW_CYCLES > READ_LATENCY_CYCLES) ? ACT_TO_RW_CYCLES
                                                                     : READ_LATENCY_CYCLES;
  localparam int DLY_MAX = (DLY_AR > RECOVER_CYCLES) ? DLY_AR : RECOVER_CYCLES;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int RD_WAIT = (READ_LATENCY_CYCLES >= 2) ? READ_LATENCY_CYCLES - 2 : 0;

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
  localparam logic [DLY_W-1:0]  ACT_LOAD    = DLY_W'(ACT_TO_RW_CYCLES - 1);
  localparam logic [DLY_W-1:0]  RDW_LOAD    = DLY_W'(RD_WAIT);
  localparam logic [DLY_W-1:0]  REC_RD_LOAD = DLY_W'(RECOVER_CYCLES - 1);
  // The controller registers write data one cycle behind the command bus, so
  // the final write beat needs one extra quiet cycle before recovery counts.
  localparam logic [DLY_W-1:0]  REC_WR_LOAD = DLY_W'(RECOVER_CYCLES);
  localparam logic [ADDRESS_BIT_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_BIT_WIDTH'(BURST_BEATS - 1);

  state_t                state_q, state_d;
  logic [DLY_W-1:0]      cnt_q, cnt_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  write_q;
  logic [LINE_W-1:0]     line_q;
  logic                  handshake;
  logic                  cmd_en_d;
  logic [2:0]            cmd_d;
  logic [DATA_BIT_WIDTH-1:0] data_d;

  assign handshake = (state_q == ST_IDLE) && req_valid;

  assign sdrc_data_len       = 8'(BURST_BEATS - 1);
  assign sdrc_precharge_ctrl = 1'b0;
  assign sdrc_power_down     = 1'b0;
  assign sdrc_selfrefresh    = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_INIT:     if (sdrc_init_done) state_d = ST_IDLE;
      ST_IDLE:     if (req_valid) state_d = ST_ACTIVATE;
      ST_ACTIVATE: begin
        state_d = ST_ACT_WAIT;
        cnt_d   = ACT_LOAD;
      end
      ST_ACT_WAIT: begin
        if (cnt_q == '0) begin
          beat_d  = '0;
          state_d = write_q ? ST_WRITE : ST_READ_CMD;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ST_WRITE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_RECOVER;
          cnt_d   = REC_WR_LOAD;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_READ_CMD: begin
        // With a latency of one the first beat arrives straight after the command.
        if (READ_LATENCY_CYCLES >= 2) begin
          state_d = ST_READ_WAIT;
          cnt_d   = RDW_LOAD;
        end else begin
          state_d = ST_READ_BEATS;
        end
      end
      ST_READ_WAIT: begin
        if (cnt_q == '0) state_d = ST_READ_BEATS;
        else             cnt_d   = cnt_q - DLY_W'(1);
      end
      ST_READ_BEATS: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_RECOVER;
          cnt_d   = REC_RD_LOAD;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - DLY_W'(1);
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    cmd_en_d = 1'b0;
    cmd_d    = CMD_NOP;
    data_d   = sdrc_data;
    unique case (state_d)
      ST_ACTIVATE: begin
        cmd_en_d = 1'b1;
        cmd_d    = CMD_ACTIVE;
      end
      ST_READ_CMD: begin
        cmd_en_d = 1'b1;
        cmd_d    = CMD_READ;
      end
      ST_WRITE: begin
        data_d = line_q[int'(beat_d)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
        if (beat_d == '0) begin
          cmd_en_d = 1'b1;
          cmd_d    = CMD_WRITE;
        end
      end
      default: ;
    endcase
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      line_q  <= '0;
    end else if (handshake) begin
      write_q <= req_write;
      line_q  <= req_line;
    end
  end

  // Registered outputs and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      sdrc_cmd_en <= 1'b0;
      sdrc_cmd    <= CMD_NOP;
      sdrc_dqm    <= 4'b1111;
      sdrc_data   <= '0;
      sdrc_addr   <= '0;
      rsp_line    <= '0;
    end else begin
      req_ready   <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      done        <= (state_d == ST_DONE);
      sdrc_cmd_en <= cmd_en_d;
      sdrc_cmd    <= cmd_d;
      sdrc_dqm    <= 4'b0000;
      sdrc_data   <= data_d;
      if (handshake) sdrc_addr <= req_address & ALIGN_MASK;
      if (state_q == ST_READ_BEATS)
        rsp_line[int'(beat_q)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] <= sdrc_rd_data;
    end
  end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// tb/tb_sdram_burst_sequencer.sv - self-checking bench for sdram_burst_sequencer

module tb_sdram_burst_sequencer;
  import sdram_pkg::*;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int BB = 8;
  localparam int LW = BB * DW;
  localparam int RL = 5;

  localparam logic [LW-1:0] LINE_A = {32'h0bba_5a50, 32'h4567_89ab, 32'hcdef_0123, 32'h3456_789a,
                                      32'hbcde_f012, 32'h2345_6789, 32'habcd_ef01, 32'h1234_5678};
  localparam logic [LW-1:0] LINE_B = {32'hb777_7707, 32'hb666_6606, 32'hb555_5505, 32'hb444_4404,
                                      32'hb333_3303, 32'hb222_2202, 32'hb111_1101, 32'hb000_0000};
  localparam logic [LW-1:0] LINE_C = {32'hc0de_0007, 32'hc0de_1006, 32'hc0de_2005, 32'hc0de_3004,
                                      32'hc0de_4003, 32'hc0de_5002, 32'hc0de_6001, 32'hc0de_7000};

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [LW-1:0] req_line, rsp_line;
  logic          done, busy;
  logic          sdrc_cmd_en;
  logic [2:0]    sdrc_cmd;
  logic [AW-1:0] sdrc_addr;
  logic [3:0]    sdrc_dqm;
  logic [DW-1:0] sdrc_data, sdrc_rd_data;
  logic [7:0]    sdrc_data_len;
  logic          sdrc_precharge_ctrl, sdrc_power_down, sdrc_selfrefresh;
  logic          sdrc_init_done;

  sdram_burst_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_line(req_line), .rsp_line(rsp_line),
    .done(done), .busy(busy),
    .sdrc_cmd_en(sdrc_cmd_en), .sdrc_cmd(sdrc_cmd), .sdrc_addr(sdrc_addr),
    .sdrc_dqm(sdrc_dqm), .sdrc_data(sdrc_data), .sdrc_data_len(sdrc_data_len),
    .sdrc_precharge_ctrl(sdrc_precharge_ctrl), .sdrc_power_down(sdrc_power_down),
    .sdrc_selfrefresh(sdrc_selfrefresh),
    .sdrc_rd_data(sdrc_rd_data), .sdrc_init_done(sdrc_init_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Cycle counter, command log and a small SDRAM memory model
  typedef struct {
    int            cyc;
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
  } cmd_rec_t;

  cmd_rec_t      cmd_log[$];
  int            cyc = 0;
  int            done_cnt = 0;
  int            nop_viol = 0;
  logic [DW-1:0] mem [0:255];
  int            act_base = 0;
  int            wr_idx = 0;
  bit            wr_on = 1'b0;
  int            rd_start = 32'h3fff_0000;
  int            rd_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (!sdrc_cmd_en && sdrc_cmd !== CMD_NOP) nop_viol <= nop_viol + 1;
    if (sdrc_cmd_en) cmd_log.push_back('{cyc: cyc, cmd: sdrc_cmd, addr: sdrc_addr});
    if (sdrc_cmd_en && sdrc_cmd == CMD_ACTIVE) act_base <= int'(sdrc_addr);
    if (rst) begin
      wr_on <= 1'b0;
    end else if (sdrc_cmd_en && sdrc_cmd == CMD_WRITE) begin
      mem[8'(act_base)] <= sdrc_data;
      wr_idx <= 1;
      wr_on  <= 1'b1;
    end else if (wr_on) begin
      mem[8'(act_base + wr_idx)] <= sdrc_data;
      wr_idx <= wr_idx + 1;
      if (wr_idx == BB - 1) wr_on <= 1'b0;
    end
    if (sdrc_cmd_en && sdrc_cmd == CMD_READ) begin
      rd_start <= cyc + RL;
      rd_base  <= act_base;
    end
    if (cyc >= rd_start && cyc < rd_start + BB) sdrc_rd_data <= mem[8'(rd_base + cyc - rd_start)];
    else                                        sdrc_rd_data <= 32'hdead_beef;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_line(input int base);
    logic [LW-1:0] l;
    for (int k = 0; k < BB; k++) l[k*DW +: DW] = mem[8'(base + k)];
    return l;
  endfunction

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
    int            exp_lat;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_rsp;
  } vec_t;

  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", LW'(req_ready), LW'(1'b1));
  endtask

  // Present one request, then wait for done; inputs are scrambled after the
  // handshake to show they are not looked at again.
  task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] line,
                       output int lat, output int hs);
    int g = 0;
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_address = a; req_line = line;
    @(negedge clk);
    hs = cyc;
    req_valid = 1'b0; req_write = !wr; req_address = '1; req_line = '1;
    while (!done && g < 100) begin
      @(negedge clk);
      g++;
    end
    lat = cyc - hs;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, hs, d0;
    cmd_log.delete();
    d0 = done_cnt;
    do_op(v.wr, v.addr, v.line, lat, hs);
    check({tag, "_latency"}, LW'(lat), LW'(v.exp_lat));
    check({tag, "_cmd_count"}, LW'(cmd_log.size()), LW'(2));
    if (cmd_log.size() == 2) begin
      check({tag, "_act_cmd"}, LW'(cmd_log[0].cmd), LW'(CMD_ACTIVE));
      check({tag, "_act_cycle"}, LW'(cmd_log[0].cyc - hs), LW'(0));
      check({tag, "_act_addr"}, LW'(cmd_log[0].addr), LW'(v.exp_addr));
      check({tag, "_rw_cmd"}, LW'(cmd_log[1].cmd), LW'(v.wr ? CMD_WRITE : CMD_READ));
      check({tag, "_rw_cycle"}, LW'(cmd_log[1].cyc - hs), LW'(2));
      check({tag, "_rw_addr"}, LW'(cmd_log[1].addr), LW'(v.exp_addr));
    end
    @(negedge clk);
    check({tag, "_done_width"}, LW'(done), LW'(1'b0));
    check({tag, "_done_count"}, LW'(done_cnt - d0), LW'(1));
    check({tag, "_addr_hold"}, LW'(sdrc_addr), LW'(v.exp_addr));
    check({tag, "_rsp_line"}, rsp_line, v.exp_rsp);
    if (v.wr) check({tag, "_mem_line"}, mem_line(int'(v.exp_addr)), v.line);
  endtask

  vec_t tbl[7];
  vec_t post[2];

  initial begin
    int hs, d0, hs_n, last_done, g;

    tbl[0] = '{1'b1, 21'h10, LINE_A, 17, 21'h10, '0};
    tbl[1] = '{1'b0, 21'h10, '1,     21, 21'h10, LINE_A};
    tbl[2] = '{1'b1, 21'h13, LINE_B, 17, 21'h10, LINE_A};
    tbl[3] = '{1'b0, 21'h17, '0,     21, 21'h10, LINE_B};
    tbl[4] = '{1'b1, 21'h2f, LINE_C, 17, 21'h28, LINE_B};
    tbl[5] = '{1'b0, 21'h28, '1,     21, 21'h28, LINE_C};
    tbl[6] = '{1'b0, 21'h11, '0,     21, 21'h10, LINE_B};
    post[0] = '{1'b1, 21'h40, LINE_C, 17, 21'h40, '0};
    post[1] = '{1'b0, 21'h43, '0,     21, 21'h40, LINE_C};

    rst = 1'b1; sdrc_init_done = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_line = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", LW'(req_ready), LW'(1'b0));
    check("rst_busy", LW'(busy), LW'(1'b1));
    check("rst_done", LW'(done), LW'(1'b0));
    check("rst_cmd_en", LW'(sdrc_cmd_en), LW'(1'b0));
    check("rst_cmd", LW'(sdrc_cmd), LW'(3'b111));
    check("rst_dqm", LW'(sdrc_dqm), LW'(4'b1111));
    check("rst_data", LW'(sdrc_data), LW'(0));
    check("rst_addr", LW'(sdrc_addr), LW'(0));
    check("rst_rsp_line", rsp_line, '0);
    check("data_len", LW'(sdrc_data_len), LW'(7));
    check("static_ctrl", LW'({sdrc_precharge_ctrl, sdrc_power_down, sdrc_selfrefresh}), LW'(0));
    rst = 1'b0;

    // Held in INIT while the controller is not ready
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("init_ready", LW'(req_ready), LW'(1'b0));
      check("init_cmd", LW'({sdrc_cmd_en, sdrc_cmd}), LW'(4'b0111));
    end
    sdrc_init_done = 1'b1;
    check("init_seen_ready", LW'(req_ready), LW'(1'b0));
    @(negedge clk);
    check("init_done_ready", LW'(req_ready), LW'(1'b1));
    check("idle_busy", LW'(busy), LW'(1'b0));
    check("idle_dqm", LW'(sdrc_dqm), LW'(4'b0000));

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset during write beat 3
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_address = 21'h40; req_line = LINE_A;
    @(negedge clk);
    hs = cyc;
    req_valid = 1'b0;
    while (cyc < hs + 5) @(negedge clk);
    check("abort_beat3_data", LW'(sdrc_data), LW'(32'hbcde_f012));
    check("abort_beat3_cmd_en", LW'(sdrc_cmd_en), LW'(1'b0));
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_cmd_en", LW'(sdrc_cmd_en), LW'(1'b0));
    check("abort_busy", LW'(busy), LW'(1'b1));
    check("abort_ready", LW'(req_ready), LW'(1'b0));
    check("abort_rsp_cleared", rsp_line, '0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", LW'(done_cnt - d0), LW'(0));
    check("abort_back_idle", LW'(req_ready), LW'(1'b1));
    run_vec(post[0], "post_wr");
    run_vec(post[1], "post_rd");

    // req_valid held across a write and two reads; init_done dropping is ignored
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_address = 21'h10; req_line = LINE_B;
    sdrc_init_done = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_line = '0;
    d0 = done_cnt; hs_n = 0; last_done = -10; g = 0;
    while (g < 200 && !(hs_n == 2 && done_cnt - d0 == 3)) begin
      @(negedge clk);
      g++;
      if (done) last_done = cyc;
      if (req_valid && req_ready) begin
        check($sformatf("held_hs%0d_first_idle", hs_n), LW'(cyc - last_done), LW'(1));
        hs_n++;
        if (hs_n == 2) begin
          @(negedge clk);
          req_valid = 1'b0;
        end
      end
    end
    check("held_handshakes", LW'(hs_n), LW'(2));
    check("held_dones", LW'(done_cnt - d0), LW'(3));
    check("held_rsp_line", rsp_line, LINE_B);
    repeat (25) @(negedge clk);
    check("held_no_extra_done", LW'(done_cnt - d0), LW'(3));
    sdrc_init_done = 1'b1;

    check("nop_when_cmd_en_low", LW'(nop_viol), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sequencer.md
# sdram_burst_sequencer

Parametrised command sequencer between the cache and the Gowin `SDRAM_Controller_HS_Top` user interface. It accepts one whole cache-line read or write request and issues the controller commands for it: ACTIVE, a NOP gap, then a READ or WRITE burst of `BURST_BEATS` words. Write beats are streamed out of a flattened line buffer. Read beats are captured into that buffer at a fixed latency. This replaces hand-driven command sequences with one reusable block that the cache instantiates.

## Interface
- `ADDRESS_BIT_WIDTH`, 21, width of controller word address
- `DATA_BIT_WIDTH`, 32, controller data width
- `BURST_BEATS`, 8, words per line; power of two, 1..256
- `ACT_TO_RW_CYCLES`, 1, NOP cycles between ACTIVE and READ/WRITE (≥1)
- `READ_LATENCY_CYCLES`, 5, cycles from READ command cycle to first valid `O_sdrc_data` beat
- `RECOVER_CYCLES`, 6, idle cycles after last beat before `done`
- `clk` in 1: single clock, also drives controller `I_sdrc_clk`
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid && req_ready`
- `req_write` in 1: 1 = write line, 0 = read line
- `req_address` in `ADDRESS_BIT_WIDTH`: line address; low log2(`BURST_BEATS`) bits forced to 0
- `req_line` in `BURST_BEATS*DATA_BIT_WIDTH`: write data, beat k at `[k*W +: W]`
- `rsp_line` out `BURST_BEATS*DATA_BIT_WIDTH`: read data, same packing
- `done` out 1: one-cycle pulse, operation complete
- `busy` out 1: not idle
- `sdrc_cmd_en`, `sdrc_cmd`[3], `sdrc_addr`, `sdrc_dqm`[4], `sdrc_data`, `sdrc_data_len`[8] out: to controller
- `sdrc_precharge_ctrl`, `sdrc_power_down`, `sdrc_selfrefresh` out 1: constant 0
- `sdrc_rd_data` in `DATA_BIT_WIDTH`, `sdrc_init_done` in 1: from controller

## Operation
- Commands: ACTIVE=3'b011, WRITE=3'b100, READ=3'b101, NOP=3'b111. `sdrc_cmd`=NOP whenever `sdrc_cmd_en`=0.
- `sdrc_data_len` = `BURST_BEATS-1`, constant. `sdrc_dqm` = 0 outside reset.
- States:
  - INIT: wait for `sdrc_init_done`, then IDLE.
  - IDLE: `req_ready`=1. On handshake, latch write flag, aligned address and `req_line`; go ACTIVATE.
  - ACTIVATE: 1 cycle, `cmd_en`=1, `cmd`=ACTIVE, `addr`=latched address.
  - ACT_WAIT: `ACT_TO_RW_CYCLES` NOP cycles.
  - WRITE: `BURST_BEATS` cycles.
    - Beat 0 cycle: `cmd_en`=1, `cmd`=WRITE, `data`=beat 0.
    - Following cycles: `cmd_en`=0, `data`=beat k.
  - READ_CMD: 1 cycle, `cmd_en`=1, `cmd`=READ.
  - READ_WAIT: `READ_LATENCY_CYCLES-1` cycles.
  - READ_BEATS: `BURST_BEATS` cycles, capturing beat k into `rsp_line[k]`.
  - RECOVER: `RECOVER_CYCLES` NOP cycles.
  - DONE: 1 cycle, `done`=1, then IDLE.
- `rsp_line` holds its value until the next read completes; write operations do not modify it.
- `sdrc_addr` holds its value through the whole operation.

## Timing
- Reset values:
  - `req_ready`=0, `done`=0, `busy`=1, `rsp_line`=0, `sdrc_data`=0, `sdrc_addr`=0.
  - `sdrc_cmd_en`=0, `sdrc_cmd`=NOP, `sdrc_dqm`=4'b1111.
  - State INIT.
- All outputs are registered.
- `busy`=0 only in IDLE. `req_ready` = !`busy`. `req_ready` drops the cycle after the handshake, so back-to-back requests are impossible.
- Write latency, handshake edge to `done` high: 1 + 1 + `ACT_TO_RW_CYCLES` + `BURST_BEATS` + `RECOVER_CYCLES` cycles. With defaults this is 17.
- Read latency, same measure: 1 + 1 + `ACT_TO_RW_CYCLES` + `READ_LATENCY_CYCLES` + `BURST_BEATS` - 1 + `RECOVER_CYCLES` cycles. With defaults this is 21.
- Beat counter width is log2(`BURST_BEATS`)+1 and it wraps only on a new operation. Delay counters size to the maximum parameter value.
- `rst` mid-operation: aborts on the next edge, all outputs take reset values, state INIT. No partial `done`.
- `sdrc_init_done` falling outside INIT: ignored.
- `req_valid` while busy: ignored. `req_*` inputs are don't-care after the handshake.

## Structure
- Package `sdram_pkg`: command constants `CMD_NOP`/`CMD_ACTIVE`/`CMD_WRITE`/`CMD_READ` as 3-bit localparams, plus the state enum typedef.
- Single module with no sub-module. The line buffer is a flat register indexed by the beat counter.

## Test plan
- Reset with `sdrc_init_done`=0:
  - `req_ready`=0 and `sdrc_cmd`=3'b111 until init done.
  - `req_ready`=1 on the cycle after `init_done` is seen.
- Write line at address 0x10 with beats 32'h1234_5678, 32'habcd_ef01, …, 32'h0bba_5a50:
  - ACTIVE carries addr 0x10, followed by 1 NOP.
  - WRITE is issued with beat 0; the 8 beats follow in order on `sdrc_data` with `data_len`=7.
  - `done` occurs 17 cycles after the handshake.
- Read line at address 0x10 against the Micron SDRAM model:
  - `rsp_line` equals the written beats.
  - `done` occurs 21 cycles after the handshake.
- Unaligned request address 0x13: all commands carry address 0x10.
- Assert `rst` during WRITE beat 3:
  - Next cycle `cmd_en`=0, `busy`=1, no `done` pulse.
  - After init done, a fresh write completes normally.
- `req_valid` held high continuously across two reads: exactly two handshakes occur, each at the first IDLE cycle, and each produces one `done` pulse.
